// File: rtl/sb_sched.sv
// Context scheduler for the 8-bit switch box: steps through a table of
// {sel, hold} entries and drives SB.sel, falling back to the all-zero route when idle.
//
// state | meaning
// IDLE  | table writable, sel_out forced to 0, waiting for start
// RUN   | applying table[ctx_idx] for its dwell, then advancing/wrapping/finishing
module sb_sched #(
   parameter int SEL_W  = 16,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_wr,
   input  logic [IDX_W-1:0]  cfg_addr,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [HOLD_W-1:0] cfg_hold,
   output logic              cfg_ready,
   output logic              cfg_err,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   input  logic [IDX_W-1:0]  last_idx,
   output logic [SEL_W-1:0]  sel_out,
   output logic [IDX_W-1:0]  ctx_idx,
   output logic              ctx_strobe,
   output logic              active,
   output logic              done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [SEL_W-1:0]  tbl_sel  [DEPTH];
   logic [HOLD_W-1:0] tbl_hold [DEPTH];
   logic [IDX_W-1:0]  last_q;
   logic [HOLD_W-1:0] cnt;
   logic              wr_ok;
   logic [HOLD_W-1:0] hold0;
   logic [IDX_W-1:0]  nxt_idx;

   // Counter holds remaining cycles minus one, so hold 0 and 1 both dwell one cycle.
   function automatic logic [HOLD_W-1:0] dwell(input logic [HOLD_W-1:0] h);
      return (h == '0) ? '0 : h - 1'b1;
   endfunction

   assign wr_ok   = cfg_wr && (state == IDLE);
   // A write to entry 0 on the start edge must be seen by the first dwell load.
   assign hold0   = (wr_ok && cfg_addr == '0) ? cfg_hold : tbl_hold[0];
   assign nxt_idx = (ctx_idx == last_q) ? '0 : ctx_idx + 1'b1;

   assign cfg_ready = (state == IDLE);
   assign active    = (state == RUN);
   assign sel_out   = active ? tbl_sel[ctx_idx] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_q     <= '0;
         cnt        <= '0;
         ctx_idx    <= '0;
         ctx_strobe <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_sel[i]  <= '0;
            tbl_hold[i] <= '0;
         end
      end else begin
         ctx_strobe <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= cfg_wr && (state != IDLE);
         if (wr_ok) begin
            tbl_sel[cfg_addr]  <= cfg_sel;
            tbl_hold[cfg_addr] <= cfg_hold;
         end
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state      <= RUN;
                  last_q     <= last_idx;
                  ctx_idx    <= '0;
                  cnt        <= dwell(hold0);
                  ctx_strobe <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state   <= IDLE;
                  ctx_idx <= '0;
                  cnt     <= '0;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (ctx_idx != last_q || loop) begin
                  ctx_idx    <= nxt_idx;
                  cnt        <= dwell(tbl_hold[nxt_idx]);
                  ctx_strobe <= 1'b1;
               end else begin
                  state   <= IDLE;
                  ctx_idx <= '0;
                  done    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sb_sched.sv
// Scoreboard bench for sb_sched: the driver predicts strobe/done/err events from
// the dwell rules, a negedge monitor pops and compares them as the DUT emits them.
module tb_sb_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [15:0] cfg_sel = '0;
   logic [7:0]  cfg_hold = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic [2:0]  last_idx = '0;
   logic        cfg_ready, cfg_err, ctx_strobe, active, done;
   logic [15:0] sel_out;
   logic [2:0]  ctx_idx;

   sb_sched dut (
      .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
      .cfg_sel(cfg_sel), .cfg_hold(cfg_hold), .cfg_ready(cfg_ready),
      .cfg_err(cfg_err), .start(start), .stop(stop), .loop(loop),
      .last_idx(last_idx), .sel_out(sel_out), .ctx_idx(ctx_idx),
      .ctx_strobe(ctx_strobe), .active(active), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   logic [15:0] m_sel  [8];
   logic [7:0]  m_hold [8];

   typedef struct {
      int          cyc;
      logic [2:0]  idx;
      logic [15:0] sel;
   } sev_t;

   sev_t sq[$];
   int   dq[$];
   int   eq[$];
   sev_t e;
   int   de;

   task automatic chk_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         while (sq.size() > 0 && sq[0].cyc < cyc) begin
            chk_eq("strobe_missed_cycle", cyc, sq[0].cyc);
            void'(sq.pop_front());
         end
         while (dq.size() > 0 && dq[0] < cyc) begin
            chk_eq("done_missed_cycle", cyc, dq[0]);
            void'(dq.pop_front());
         end
         while (eq.size() > 0 && eq[0] < cyc) begin
            chk_eq("err_missed_cycle", cyc, eq[0]);
            void'(eq.pop_front());
         end
         if (ctx_strobe) begin
            if (sq.size() == 0) chk_eq("strobe_unexpected", ctx_strobe, 0);
            else begin
               e = sq.pop_front();
               chk_eq("strobe_cycle", cyc, e.cyc);
               chk_eq("strobe_idx", ctx_idx, e.idx);
               chk_eq("strobe_sel", sel_out, e.sel);
            end
         end
         if (done) begin
            if (dq.size() == 0) chk_eq("done_unexpected", done, 0);
            else begin
               de = dq.pop_front();
               chk_eq("done_cycle", cyc, de);
               chk_eq("done_active", active, 0);
               chk_eq("done_cfg_ready", cfg_ready, 1);
            end
         end
         if (cfg_err) begin
            if (eq.size() == 0) chk_eq("err_unexpected", cfg_err, 0);
            else begin
               de = eq.pop_front();
               chk_eq("err_cycle", cyc, de);
            end
         end
         if (active) chk_eq("sel_live", sel_out, m_sel[ctx_idx]);
         else        chk_eq("sel_idle", sel_out, 0);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
      cfg_wr = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] s, input logic [7:0] h);
      cfg_wr = 1'b1; cfg_addr = a; cfg_sel = s; cfg_hold = h;
      m_sel[a] = s; m_hold[a] = h;
      step();
   endtask

   // Starts a run in the current cycle and returns on the cycle after it ends
   // (the done cycle for a natural finish).
   task automatic run(input logic [2:0] last, input bit loop0, input int drop_off,
                      input int stop_off, input bit use_rst, input bit ws,
                      input logic [15:0] ws_sel, input logic [7:0] ws_hold,
                      input bit want_wr, input bit want_ign);
      int c, t, ec, d, s_cyc, drop_cyc, end_c, wr_k, ign_k, guard;
      bit stopped;
      logic [2:0] i;
      c = cyc; wr_k = 0; ign_k = 0; guard = 0; stopped = 1'b0; i = '0; end_c = c;
      if (ws) begin
         cfg_wr = 1'b1; cfg_addr = '0; cfg_sel = ws_sel; cfg_hold = ws_hold;
         m_sel[0] = ws_sel; m_hold[0] = ws_hold;
      end
      start = 1'b1; last_idx = last; loop = loop0;
      s_cyc    = (stop_off > 0) ? c + stop_off : 32'h7fffffff;
      drop_cyc = loop0 ? ((drop_off > 0) ? c + drop_off : 32'h7fffffff) : c;
      t = c + 1;
      forever begin
         sq.push_back(sev_t'{t, i, m_sel[i]});
         d  = (m_hold[i] == 0) ? 1 : int'(m_hold[i]);
         ec = t + d - 1;
         if (ec >= s_cyc) begin stopped = 1'b1; end_c = s_cyc; break; end
         if (i == last) begin
            if (ec >= drop_cyc) begin dq.push_back(ec + 1); end_c = ec; break; end
            i = '0;
         end else i = i + 1'b1;
         t = ec + 1;
         guard++;
         if (guard > 20000) begin
            $display("FAIL model_guard: got %0d expected below 20000", guard);
            $fatal(1);
         end
      end
      if (want_wr && end_c - c >= 2) wr_k = int'($urandom_range(1, end_c - c - 1));
      if (want_ign && end_c - c >= 2) ign_k = int'($urandom_range(1, end_c - c - 1));
      for (int k = 1; k <= end_c - c; k++) begin
         step();
         if (loop0 && k == drop_off) loop = 1'b0;
         if (k == ign_k) start = 1'b1;
         if (k == wr_k) begin
            cfg_wr = 1'b1; cfg_addr = 3'($urandom); cfg_sel = 16'($urandom);
            cfg_hold = 8'($urandom);
            eq.push_back(cyc + 1);
         end
         if (stopped && k == end_c - c) begin
            if (use_rst) rst_n = 1'b0;
            else stop = 1'b1;
         end
      end
      step();
      loop = 1'b0;
      if (stopped) begin
         chk_eq("halt_active", active, 0);
         chk_eq("halt_sel", sel_out, 0);
         chk_eq("halt_done", done, 0);
         if (use_rst) begin
            for (int j = 0; j < 8; j++) begin m_sel[j] = '0; m_hold[j] = '0; end
            chk_eq("rst_ctx_idx", ctx_idx, 0);
            chk_eq("rst_strobe", ctx_strobe, 0);
            chk_eq("rst_cfg_err", cfg_err, 0);
            chk_eq("rst_cfg_ready", cfg_ready, 1);
            rst_n = 1'b1;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      for (int j = 0; j < 8; j++) begin m_sel[j] = '0; m_hold[j] = '0; end
      step();
      step();
      chk_eq("reset_sel", sel_out, 0);
      chk_eq("reset_cfg_ready", cfg_ready, 1);
      chk_eq("reset_active", active, 0);
      chk_eq("reset_strobe", ctx_strobe, 0);
      chk_eq("reset_done", done, 0);
      chk_eq("reset_err", cfg_err, 0);
      chk_eq("reset_idx", ctx_idx, 0);
      mon_en = 1'b1;
      rst_n = 1'b1;
      step();

      wr(3'd0, 16'd1, 8'd2);
      stop = 1'b1;
      step();
      step();
      chk_eq("idle_stop_active", active, 0);
      chk_eq("idle_stop_ready", cfg_ready, 1);

      wr(3'd1, 16'd4, 8'd3);
      run(3'd1, 1'b0, 0, 0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
      run(3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);

      wr(3'd0, 16'd12, 8'd0);
      run(3'd0, 1'b1, 6, 0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);

      wr(3'd0, 16'd7, 8'd100);
      run(3'd0, 1'b0, 0, 5, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);

      wr(3'd0, 16'd9, 8'd10);
      run(3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b1, 1'b1);
      run(3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);

      start = 1'b1; stop = 1'b1;
      step();
      chk_eq("start_stop_active", active, 0);
      step();
      chk_eq("start_stop_active2", active, 0);

      run(3'd0, 1'b0, 0, 0, 1'b0, 1'b1, 16'd100, 8'd2, 1'b0, 1'b0);

      wr(3'd0, 16'd5, 8'd50);
      run(3'd0, 1'b0, 0, 7, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         bit lp;
         int dro, sto;
         for (int a = 0; a < 8; a++)
            if ($urandom_range(0, 2) != 0)
               wr(3'(a), 16'($urandom), 8'($urandom_range(0, 6)));
         lp  = 1'($urandom);
         dro = lp ? int'($urandom_range(1, 40)) : 0;
         sto = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
         run(3'($urandom), lp, dro, sto, ($urandom_range(0, 5) == 0),
             1'($urandom), 16'($urandom), 8'($urandom_range(0, 6)),
             1'($urandom), 1'($urandom));
      end

      step();
      step();
      chk_eq("pending_strobes", sq.size(), 0);
      chk_eq("pending_dones", dq.size(), 0);
      chk_eq("pending_errs", eq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
